bram_fifo_ctrl: RTL and testbench
=================================

// Module: bram_fifo_ctrl
// PURPOSE
//  Synchronous FIFO controller that drives an external simple dual-port block RAM.
//  - RAM contract: 1-cycle registered read; a same-address read and write in one cycle returns the old data.
//  - The block owns the write/read pointers and the full/empty flags.
//  - It hides RAM read latency behind a 2-entry output skid stage, presenting a first-word-fall-through
//    (FWFT) interface to the consumer at full throughput.
//  - Sits directly upstream of the RAM; all RAM address/enable ports are generated here.
// PARAMETERS
//  DATA_WIDTH  8  width of stored word
//  ADDR_WIDTH  4  RAM address width; FIFO capacity DEPTH = 2**ADDR_WIDTH entries
// PORTS
//  clk         in   1           single clock, all logic on posedge
//  reset       in   1           synchronous, active-high
//  wr          in   1           push request; accepted iff !full
//  w_data      in   DATA_WIDTH  push data
//  rd          in   1           pop request; accepted iff !empty
//  r_data      out  DATA_WIDTH  head word, valid whenever !empty (FWFT)
//  empty       out  1           no word available at r_data
//  full        out  1           DEPTH words held; pushes ignored
//  ram_wr_en   out  1           RAM write enable
//  ram_w_addr  out  ADDR_WIDTH  RAM write address
//  ram_w_data  out  DATA_WIDTH  RAM write data (= w_data)
//  ram_r_addr  out  ADDR_WIDTH  RAM read address
//  ram_r_data  in   DATA_WIDTH  RAM read data, valid 1 cycle after a launch
//  level       out  ADDR_WIDTH+1 total occupancy (only with FIFO_LEVEL_EN)
// BEHAVIOUR
//  - Reset: w_ptr=r_ptr=0, count=0, in-flight=0, skid state EMPTY, r_data=0, empty=1, full=0, level=0.
//  - push = wr & !full. On push: ram_wr_en=1, ram_w_addr=w_ptr, w_ptr+1 (wraps mod DEPTH).
//  - pop = rd & !empty. Removes the skid head.
//  - Overflow/underflow requests are dropped silently; no state changes.
//  - ram_cnt counts words in RAM that are not yet launched.
//    A word pushed in cycle N is launchable no earlier than N+1, so a launch never collides with a same-cycle write.
//  - Launch condition: ram_cnt>0 & (skid_cnt + inflight - pop) < 2.
//    On launch: ram_r_addr=r_ptr, r_ptr+1 (wraps), inflight<=1.
//  - When inflight=1, ram_r_data is loaded into the skid (head slot if it is free after the pop, else the spare slot).
//  - Skid FSM, states EMPTY/ONE/TWO:
//      EMPTY->ONE on load; ONE->TWO on load & !pop; ONE->EMPTY on pop & !load;
//      TWO->ONE on pop (spare moves to head). Load & pop in ONE stays ONE with the new head.
//  - empty = (skid state == EMPTY), registered.
//  - full: registered, count == DEPTH; count = ram_cnt + inflight + skid_cnt, in 0..DEPTH.
//  - Simultaneous push & pop when full: pop accepted, push rejected (flags are current-cycle registered values).
//  - Simultaneous push & pop when empty: push accepted, pop ignored.
//  - Latency: push into an empty FIFO at cycle 0 gives empty=0 with valid r_data at cycle 3.
//  - Throughput: 1 push + 1 pop per cycle sustained.
//  - Reset mid-operation discards all contents; in-flight RAM data is ignored. RAM contents are not cleared.
// CONFIGURATION
//  - FIFO_LEVEL_EN defined: level port present and driven by registered count; it updates the same cycle as full/empty.
//  - FIFO_LEVEL_EN undefined: level port and its register absent; core behaviour identical.
// STRUCTURE
//  - Package bram_fifo_pkg: typedef enum logic[1:0] skid_state_t {SKID_EMPTY, SKID_ONE, SKID_TWO}; localparam SKID_DEPTH=2.
//  - Sub-module fifo_skid_buf (DATA_WIDTH): load/ram data in, pop in, head data/state out.
//  - Top keeps pointers, ram_cnt, inflight, count and the flags.
// TESTING
//  1. Reset: empty=1, full=0, r_data=0, ram_wr_en=0; rd asserted for 5 cycles changes nothing.
//  2. Push 0xA5 at cycle 0 into an empty FIFO -> empty=0, r_data=0xA5 at cycle 3; pop -> empty=1 next cycle.
//  3. Push 16 words 0x00..0x0F (ADDR_WIDTH=4) -> full=1 after the 16th; a 17th push with 0xFF is dropped;
//     popping all 16 returns 0x00..0x0F in order, then empty=1.
//  4. Streaming: wr&rd every cycle for 100 cycles after priming 4 words -> no bubbles, data in order, occupancy stays 4.
//  5. Full + simultaneous wr&rd: head popped, new word dropped, full deasserts next cycle.
//  6. Assert reset while 3 words are stored and one is in flight -> next cycle empty=1, count=0;
//     the next push/pop returns the new data, never stale.

Source files
------------

// File: rtl/bram_fifo_pkg.sv
// Shared types for the BRAM-backed FWFT FIFO controller: skid-stage state
// encoding and its occupancy helper.
package bram_fifo_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

    localparam int unsigned SKID_DEPTH = 2;

    function automatic logic [1:0] skid_count(input skid_state_t s);
        case (s)
            SKID_ONE: return 2'd1;
            SKID_TWO: return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/bram_fifo_ctrl_if.sv
// Producer/consumer and RAM-side signal bundle for bram_fifo_ctrl.
// The level signal exists only when FIFO_LEVEL_EN is defined.
interface bram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  rd;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  empty;
    logic                  full;
    logic                  ram_wr_en;
    logic [ADDR_WIDTH-1:0] ram_w_addr;
    logic [DATA_WIDTH-1:0] ram_w_data;
    logic [ADDR_WIDTH-1:0] ram_r_addr;
    logic [DATA_WIDTH-1:0] ram_r_data;
`ifdef FIFO_LEVEL_EN
    logic [ADDR_WIDTH:0]   level;
`endif

    modport slave (
        input  wr, w_data, rd, ram_r_data,
        output r_data, empty, full, ram_wr_en, ram_w_addr, ram_w_data, ram_r_addr
`ifdef FIFO_LEVEL_EN
        , output level
`endif
    );

    modport master (
        output wr, w_data, rd, ram_r_data,
        input  r_data, empty, full, ram_wr_en, ram_w_addr, ram_w_data, ram_r_addr
`ifdef FIFO_LEVEL_EN
        , input level
`endif
    );

endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry output skid stage: absorbs registered RAM read data and presents
// the oldest word at o_head (first-word-fall-through).
module fifo_skid_buf
    import bram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_load_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head,
    output skid_state_t           o_state
);

    skid_state_t           r_state;
    skid_state_t           w_state_next;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_spare;
    logic                  w_head_we;
    logic                  w_head_from_spare;
    logic                  w_spare_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SKID_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SKID_EMPTY: if (i_load) w_state_next = SKID_ONE;
            SKID_ONE: begin
                if (i_load && !i_pop)      w_state_next = SKID_TWO;
                else if (!i_load && i_pop) w_state_next = SKID_EMPTY;
            end
            SKID_TWO:   if (i_pop && !i_load) w_state_next = SKID_ONE;
            default:    w_state_next = SKID_EMPTY;
        endcase
    end

    // In TWO a pop promotes the spare; a load then refills the spare slot.
    always_comb begin
        w_head_we         = 1'b0;
        w_head_from_spare = 1'b0;
        w_spare_we        = 1'b0;
        case (r_state)
            SKID_EMPTY: w_head_we = i_load;
            SKID_ONE: begin
                w_head_we  = i_load && i_pop;
                w_spare_we = i_load && !i_pop;
            end
            SKID_TWO: begin
                w_head_we         = i_pop;
                w_head_from_spare = i_pop;
                w_spare_we        = i_load && i_pop;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_spare <= '0;
        end else begin
            if (w_head_we)  r_head  <= w_head_from_spare ? r_spare : i_load_data;
            if (w_spare_we) r_spare <= i_load_data;
        end
    end

    assign o_head  = r_head;
    assign o_state = r_state;

endmodule

// File: rtl/bram_fifo_ctrl.sv
// FWFT FIFO controller for an external 1-cycle-read simple dual-port RAM.
// Optional occupancy output enabled by defining FIFO_LEVEL_EN.
module bram_fifo_ctrl
    import bram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    bram_fifo_ctrl_if.slave  bus
);

    localparam logic [ADDR_WIDTH:0]   CNT_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_ram_cnt;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_inflight;
    logic                  r_full;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_launch;
    logic                  w_empty;
    logic [1:0]            w_skid_cnt;
    logic [2:0]            w_occ;
    logic [2:0]            w_limit;
    logic [ADDR_WIDTH:0]   w_count_next;
    logic [ADDR_WIDTH:0]   w_ram_cnt_next;
    logic [DATA_WIDTH-1:0] w_head;
    skid_state_t           w_skid_state;

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .i_load      (r_inflight),
        .i_load_data (bus.ram_r_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_state     (w_skid_state)
    );

    assign w_empty    = (w_skid_state == SKID_EMPTY);
    assign w_push     = bus.wr && !r_full;
    assign w_pop      = bus.rd && !w_empty;
    assign w_skid_cnt = skid_count(w_skid_state);

    // Launch only if the word will still fit once the in-flight read and this pop settle.
    assign w_occ    = {1'b0, w_skid_cnt} + {2'b00, r_inflight};
    assign w_limit  = 3'(SKID_DEPTH) + {2'b00, w_pop};
    assign w_launch = (r_ram_cnt != '0) && (w_occ < w_limit);

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop)      w_count_next = r_count + CNT_ONE;
        else if (!w_push && w_pop) w_count_next = r_count - CNT_ONE;
    end

    always_comb begin
        w_ram_cnt_next = r_ram_cnt;
        if (w_push && !w_launch)      w_ram_cnt_next = r_ram_cnt + CNT_ONE;
        else if (!w_push && w_launch) w_ram_cnt_next = r_ram_cnt - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_ram_cnt  <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_full     <= 1'b0;
        end else begin
            if (w_push)   r_wptr <= r_wptr + PTR_ONE;
            if (w_launch) r_rptr <= r_rptr + PTR_ONE;
            r_ram_cnt  <= w_ram_cnt_next;
            r_count    <= w_count_next;
            r_inflight <= w_launch;
            r_full     <= (w_count_next == FULL_COUNT);
        end
    end

    assign bus.r_data     = w_head;
    assign bus.empty      = w_empty;
    assign bus.full       = r_full;
    assign bus.ram_wr_en  = w_push;
    assign bus.ram_w_addr = r_wptr;
    assign bus.ram_w_data = bus.w_data;
    assign bus.ram_r_addr = r_rptr;

`ifdef FIFO_LEVEL_EN
    assign bus.level = r_count;
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Self-checking bench for bram_fifo_ctrl with a behavioural 1-cycle-read RAM
// and a queue scoreboard of pushed words.
module tb_bram_fifo_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bram_fifo_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    bram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Registered read returns old contents on a same-address write.
    logic [7:0] ram_mem [16];
    always @(posedge clk) begin
        if (bus.ram_wr_en) ram_mem[bus.ram_w_addr] <= bus.ram_w_data;
        bus.ram_r_data <= ram_mem[bus.ram_r_addr];
    end

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;
    logic [7:0] exp_q [$];

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic wr_v, input logic [7:0] wd, input logic rd_v,
                        output logic popped, output logic [7:0] got);
        popped = rd_v && (bus.empty === 1'b0);
        got    = bus.r_data;
        bus.wr = wr_v; bus.w_data = wd; bus.rd = rd_v;
        if (wr_v && model_cnt < 16) begin
            exp_q.push_back(wd);
            model_cnt++;
        end
        if (popped) model_cnt--;
        @(posedge clk); #1;
        bus.wr = 1'b0; bus.rd = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.wr = 1'b0; bus.rd = 1'b0; bus.w_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete(); model_cnt = 0;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", bus.full); end
        checks++; if (bus.r_data !== 8'h00) begin errors++; $display("FAIL reset_rdata got %0h want 0", bus.r_data); end
        checks++; if (bus.ram_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wren got %0b want 0", bus.ram_wr_en); end
`ifdef FIFO_LEVEL_EN
        checks++; if (bus.level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", bus.level); end
`endif
        for (int i = 0; i < 5; i++) begin
            bus.rd = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.r_data !== 8'h00) begin
                errors++;
                $display("FAIL underflow_rd got empty=%0b full=%0b rdata=%0h want 1 0 0", bus.empty, bus.full, bus.r_data);
            end
        end
        bus.rd = 1'b0;
    endtask

    task automatic test_latency();
        logic popped; logic [7:0] got, exp;
        bus.wr = 1'b1; bus.w_data = 8'hA5; bus.rd = 1'b0;
        #1;
        checks++; if (bus.ram_wr_en !== 1'b1) begin errors++; $display("FAIL push_wren got %0b want 1", bus.ram_wr_en); end
        checks++; if (bus.ram_w_addr !== 4'd0) begin errors++; $display("FAIL push_waddr got %0d want 0", bus.ram_w_addr); end
        checks++; if (bus.ram_w_data !== 8'hA5) begin errors++; $display("FAIL push_wdata got %0h want a5", bus.ram_w_data); end
        exp_q.push_back(8'hA5); model_cnt++;
        @(posedge clk); #1;
        bus.wr = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (bus.empty !== (c < 3 ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL latency_empty_c%0d got %0b want %0b", c, bus.empty, (c < 3));
            end
            if (c < 3) step(1'b0, 8'h00, 1'b0, popped, got);
        end
        step(1'b0, 8'h00, 1'b1, popped, got);
        checks++;
        if (!popped) begin errors++; $display("FAIL latency_pop got none want a5"); end
        else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin errors++; $display("FAIL latency_data got %0h want %0h", got, exp); end
        end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL latency_empty_after got %0b want 1", bus.empty); end
    endtask

    task automatic test_fill();
        logic popped; logic [7:0] got, exp;
        int pops = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0, popped, got);
            checks++;
            if (bus.full !== (i == 15)) begin errors++; $display("FAIL fill_full_%0d got %0b want %0b", i, bus.full, (i == 15)); end
        end
        bus.wr = 1'b1; bus.w_data = 8'hFF;
        #1;
        checks++; if (bus.ram_wr_en !== 1'b0) begin errors++; $display("FAIL overflow_wren got %0b want 0", bus.ram_wr_en); end
        @(posedge clk); #1;
        bus.wr = 1'b0;
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL overflow_full got %0b want 1", bus.full); end
        for (int c = 0; c < 80 && pops < 16; c++) begin
            step(1'b0, 8'h00, 1'b1, popped, got);
            if (popped) begin
                pops++;
                exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin errors++; $display("FAIL fill_order got %0h want %0h", got, exp); end
            end
        end
        checks++; if (pops != 16) begin errors++; $display("FAIL fill_drain_count got %0d want 16", pops); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL fill_empty_after got %0b want 1", bus.empty); end
    endtask

    task automatic test_full_wr_rd();
        logic popped; logic [7:0] got, exp;
        int pops = 0;
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i) + 8'h30, 1'b0, popped, got);
        repeat (4) step(1'b0, 8'h00, 1'b0, popped, got);
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fullrw_full_before got %0b want 1", bus.full); end
        step(1'b1, 8'hEE, 1'b1, popped, got);
        checks++;
        if (!popped) begin errors++; $display("FAIL fullrw_pop got none want 30"); end
        else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin errors++; $display("FAIL fullrw_head got %0h want %0h", got, exp); end
        end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL fullrw_full_after got %0b want 0", bus.full); end
        for (int c = 0; c < 80 && pops < 15; c++) begin
            step(1'b0, 8'h00, 1'b1, popped, got);
            if (popped) begin
                pops++;
                exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin errors++; $display("FAIL fullrw_order got %0h want %0h", got, exp); end
            end
        end
        checks++; if (pops != 15) begin errors++; $display("FAIL fullrw_drain_count got %0d want 15", pops); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL fullrw_dropped got empty=%0b want 1", bus.empty); end
    endtask

    task automatic test_stream();
        logic popped; logic [7:0] got, exp;
        int pops = 0;
        for (int i = 0; i < 4; i++) step(1'b1, 8'(i) + 8'h40, 1'b0, popped, got);
        repeat (4) step(1'b0, 8'h00, 1'b0, popped, got);
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 8'(i) + 8'h50, 1'b1, popped, got);
            checks++;
            if (!popped) begin errors++; $display("FAIL stream_bubble_%0d got empty want data", i); end
            else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin errors++; $display("FAIL stream_data_%0d got %0h want %0h", i, got, exp); end
            end
            checks++;
            if (bus.full !== 1'b0) begin errors++; $display("FAIL stream_full_%0d got %0b want 0", i, bus.full); end
`ifdef FIFO_LEVEL_EN
            checks++;
            if (bus.level !== 5'd4) begin errors++; $display("FAIL stream_level_%0d got %0d want 4", i, bus.level); end
`endif
        end
        for (int c = 0; c < 40 && !(bus.empty === 1'b1 && c > 4); c++) begin
            step(1'b0, 8'h00, 1'b1, popped, got);
            if (popped) begin
                pops++;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL stream_tail got %0h want none", got); end
                else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin errors++; $display("FAIL stream_tail got %0h want %0h", got, exp); end
                end
            end
        end
        checks++; if (pops != 4) begin errors++; $display("FAIL stream_occupancy got %0d want 4", pops); end
    endtask

    task automatic test_reset_mid();
        logic popped; logic [7:0] got, exp;
        int pops = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 8'(i) + 8'h60, 1'b0, popped, got);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete(); model_cnt = 0;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL midreset_empty got %0b want 1", bus.empty); end
        checks++; if (bus.full !== 1'b0 || bus.r_data !== 8'h00) begin
            errors++; $display("FAIL midreset_flags got full=%0b rdata=%0h want 0 0", bus.full, bus.r_data);
        end
`ifdef FIFO_LEVEL_EN
        checks++; if (bus.level !== 5'd0) begin errors++; $display("FAIL midreset_level got %0d want 0", bus.level); end
`endif
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 8'h00, 1'b0, popped, got);
            checks++;
            if (bus.empty !== 1'b1) begin errors++; $display("FAIL midreset_stale_%0d got empty=%0b want 1", c, bus.empty); end
        end
        step(1'b1, 8'h71, 1'b0, popped, got);
        step(1'b1, 8'h72, 1'b0, popped, got);
        for (int c = 0; c < 20 && pops < 2; c++) begin
            step(1'b0, 8'h00, 1'b1, popped, got);
            if (popped) begin
                pops++;
                exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin errors++; $display("FAIL midreset_data got %0h want %0h", got, exp); end
            end
        end
        checks++; if (pops != 2) begin errors++; $display("FAIL midreset_count got %0d want 2", pops); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL midreset_empty_end got %0b want 1", bus.empty); end
    endtask

    initial begin
        bus.wr = 1'b0; bus.rd = 1'b0; bus.w_data = '0; reset = 1'b1;
        test_reset();
        test_latency();
        test_fill();
        test_full_wr_rd();
        test_stream();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
